// File: rtl/tri_proj.sv
// Perspective projection of one vertex: IEEE-754 (x,y,z) -> Q16.16 -> x*F/z, y*F/z -> saturated screen pixel and depth.
// One vertex in flight at a time; each divide is a 40-step restoring divider.
module tri_proj #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int FOCAL    = 256
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [3:0][31:0] coor_in,
    input  logic             valid_in,
    input  logic             obj_done_in,
    output logic             ready_out,
    output logic [2:0][8:0]  coor_out,
    output logic             valid_out,
    output logic             obj_done_out,
    input  logic             ready_in,
    output logic [2:0]       state_dbg
);

    // Handshake: an input transfers on a rising edge with valid_in && ready_out;
    // an output transfers on a rising edge with valid_out && ready_in, and coor_out,
    // obj_done_out and valid_out hold stable until that edge.

    typedef enum logic [2:0] {IDLE, CONV, DIVX, DIVY, OUT} state_t;

    state_t             state;
    logic [31:0]        x_f, y_f, z_f;
    logic               done_r;
    logic signed [31:0] y_q, z_q;
    logic               x_neg;
    logic [39:0]        dvd;
    logic [31:0]        rem;
    logic [5:0]         cnt;
    logic signed [40:0] qx, qy;

    // Float to signed Q16.16, truncating toward zero; out-of-range saturates by sign.
    function automatic logic signed [31:0] f2q(input logic [31:0] f);
        logic [7:0]  e;
        logic [31:0] m;
        logic [31:0] mag;
        e   = f[30:23];
        m   = {8'b0, 1'b1, f[22:0]};
        if (e < 8'd111)      mag = 32'd0;
        else if (e >= 8'd142) mag = 32'h7FFF_FFFF;
        else if (e >= 8'd134) mag = m << (e - 8'd134);
        else                  mag = m >> (8'd134 - e);
        return f[31] ? $signed(-mag) : $signed(mag);
    endfunction

    function automatic logic [39:0] scaled_mag(input logic signed [31:0] v);
        logic [31:0] mag;
        mag = v[31] ? 32'(-v) : 32'(v);
        return {8'b0, mag} * 40'(FOCAL);
    endfunction

    function automatic logic signed [40:0] apply_sign(input logic neg, input logic [39:0] q);
        return neg ? -$signed({1'b0, q}) : $signed({1'b0, q});
    endfunction

    logic signed [31:0] x_conv, y_conv, z_conv, z_clamp;
    logic [32:0]        rem_sh;
    logic               ge;
    logic [31:0]        rem_nxt;
    logic [39:0]        quo_nxt;
    logic signed [41:0] sx, sy;
    logic [8:0]         sx_sat, sy_sat, depth_sat;

    always_comb begin
        x_conv  = f2q(x_f);
        y_conv  = f2q(y_f);
        z_conv  = f2q(z_f);
        z_clamp = (z_conv < 32'sh0001_0000) ? 32'sh0001_0000 : z_conv;

        rem_sh  = {rem, dvd[39]};
        ge      = rem_sh >= {1'b0, z_q};
        rem_nxt = ge ? 32'(rem_sh - {1'b0, z_q}) : rem_sh[31:0];
        quo_nxt = {dvd[38:0], ge};

        sx = $signed(42'(SCREEN_W / 2)) + $signed({qx[40], qx});
        sy = $signed(42'(SCREEN_H / 2)) - $signed({qy[40], qy});
        if (sx < 42'sd0)                             sx_sat = 9'd0;
        else if (sx > $signed(42'(SCREEN_W - 1)))    sx_sat = 9'(SCREEN_W - 1);
        else                                         sx_sat = sx[8:0];
        if (sy < 42'sd0)                             sy_sat = 9'd0;
        else if (sy > $signed(42'(SCREEN_H - 1)))    sy_sat = 9'(SCREEN_H - 1);
        else                                         sy_sat = sy[8:0];
        depth_sat = (z_q[31:16] > 16'd511) ? 9'd511 : z_q[24:16];
    end

    assign state_dbg = state;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            ready_out    <= 1'b1;
            valid_out    <= 1'b0;
            obj_done_out <= 1'b0;
            coor_out     <= '0;
            x_f          <= '0;
            y_f          <= '0;
            z_f          <= '0;
            done_r       <= 1'b0;
            y_q          <= '0;
            z_q          <= '0;
            x_neg        <= 1'b0;
            dvd          <= '0;
            rem          <= '0;
            cnt          <= '0;
            qx           <= '0;
            qy           <= '0;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    x_f       <= coor_in[3];
                    y_f       <= coor_in[2];
                    z_f       <= coor_in[1];
                    done_r    <= obj_done_in;
                    ready_out <= 1'b0;
                    state     <= CONV;
                end
                CONV: begin
                    y_q   <= y_conv;
                    z_q   <= z_clamp;
                    x_neg <= x_conv[31];
                    dvd   <= scaled_mag(x_conv);
                    rem   <= '0;
                    cnt   <= '0;
                    state <= DIVX;
                end
                DIVX: begin
                    rem <= rem_nxt;
                    dvd <= quo_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd39) begin
                        // Reload the divider with the y dividend as x finishes.
                        qx    <= apply_sign(x_neg, quo_nxt);
                        dvd   <= scaled_mag(y_q);
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIVY;
                    end
                end
                DIVY: begin
                    rem <= rem_nxt;
                    dvd <= quo_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd39) begin
                        qy    <= apply_sign(y_q[31], quo_nxt);
                        cnt   <= '0;
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (!valid_out) begin
                        coor_out     <= {sx_sat, sy_sat, depth_sat};
                        obj_done_out <= done_r;
                        valid_out    <= 1'b1;
                    end else if (ready_in) begin
                        valid_out <= 1'b0;
                        ready_out <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_proj.sv
// Directed bench for tri_proj: known vertices, saturation, back-pressure hold,
// mid-divide reset and first acceptance straight out of reset.
module tb_tri_proj;

    localparam logic [31:0] F_W1 = 32'h3F80_0000;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [3:0][31:0] coor_in;
    logic             valid_in;
    logic             obj_done_in;
    logic             ready_out;
    logic [2:0][8:0]  coor_out;
    logic             valid_out;
    logic             obj_done_out;
    logic             ready_in;
    logic [2:0]       state_dbg;

    int n_checks = 0;
    int n_errs   = 0;

    tri_proj dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .coor_in      (coor_in),
        .valid_in     (valid_in),
        .obj_done_in  (obj_done_in),
        .ready_out    (ready_out),
        .coor_out     (coor_out),
        .valid_out    (valid_out),
        .obj_done_out (obj_done_out),
        .ready_in     (ready_in),
        .state_dbg    (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    // Presents one vertex and returns right after its accepting edge (+1).
    task automatic accept(input logic [31:0] fx, fy, fz, input logic done);
        int w;
        w = 0;
        while (!ready_out && w < 200) begin
            @(posedge clk_in); #1; w++;
        end
        n_checks++;
        if (ready_out !== 1'b1) begin
            n_errs++;
            $display("FAIL accept_ready: ready_out=%0b required 1", ready_out);
        end
        coor_in     = {fx, fy, fz, F_W1};
        obj_done_in = done;
        valid_in    = 1'b1;
        @(posedge clk_in); #1;
        valid_in    = 1'b0;
        obj_done_in = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 200 && valid_out !== 1'b1) begin
            @(posedge clk_in); #1; cyc++;
        end
    endtask

    task automatic check_out(input string name, input int cyc, input logic [8:0] ex, ey, ez,
                             input logic ed);
        n_checks++;
        if (cyc !== 82) begin
            n_errs++;
            $display("FAIL %s latency: got %0d cycles required 82", name, cyc);
        end
        n_checks++;
        if (coor_out !== {ex, ey, ez}) begin
            n_errs++;
            $display("FAIL %s coor: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", name,
                     coor_out[2], coor_out[1], coor_out[0], ex, ey, ez);
        end
        n_checks++;
        if (obj_done_out !== ed) begin
            n_errs++;
            $display("FAIL %s obj_done: got %0b required %0b", name, obj_done_out, ed);
        end
    endtask

    task automatic run_vertex(input string name, input logic [31:0] fx, fy, fz, input logic done,
                              input logic [8:0] ex, ey, ez);
        int cyc;
        ready_in = 1'b1;
        accept(fx, fy, fz, done);
        n_checks++;
        if (ready_out !== 1'b0) begin
            n_errs++;
            $display("FAIL %s busy: ready_out=%0b required 0", name, ready_out);
        end
        wait_valid(cyc);
        check_out(name, cyc, ex, ey, ez, done);
        @(posedge clk_in); #1;
        n_checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            n_errs++;
            $display("FAIL %s release: valid_out=%0b ready_out=%0b required 0/1", name,
                     valid_out, ready_out);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0; valid_in = 1'b0; obj_done_in = 1'b0; ready_in = 1'b1; coor_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || obj_done_out !== 1'b0 || coor_out !== '0 || state_dbg !== 3'd0) begin
            n_errs++;
            $display("FAIL reset_state: valid=%0b done=%0b coor=%h state=%0d required 0/0/0/0",
                     valid_out, obj_done_out, coor_out, state_dbg);
        end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        n_checks++;
        if (ready_out !== 1'b1) begin
            n_errs++;
            $display("FAIL reset_ready: ready_out=%0b required 1", ready_out);
        end
    endtask

    task automatic test_projection();
        run_vertex("origin",   32'h0000_0000, 32'h0000_0000, 32'h4120_0000, 1'b0, 9'd160, 9'd120, 9'd10);
        run_vertex("unit",     32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0, 9'd224, 9'd56,  9'd4);
        run_vertex("negative", 32'hC000_0000, 32'hBF80_0000, 32'h4100_0000, 1'b0, 9'd96,  9'd152, 9'd8);
        run_vertex("z_clamp",  32'h3F00_0000, 32'h0000_0000, 32'h3F00_0000, 1'b0, 9'd288, 9'd120, 9'd1);
    endtask

    task automatic test_saturation();
        run_vertex("screen_sat", 32'h4120_0000, 32'hC120_0000, 32'h4000_0000, 1'b0, 9'd319, 9'd239, 9'd2);
        // +Inf and +NaN both saturate to the largest positive Q16.16.
        run_vertex("inf_nan",    32'h7F80_0000, 32'h7FC0_0000, 32'h4080_0000, 1'b0, 9'd319, 9'd0,   9'd4);
        run_vertex("depth_sat",  32'h0000_0000, 32'h0000_0000, 32'h447A_0000, 1'b0, 9'd160, 9'd120, 9'd511);
    endtask

    task automatic test_obj_done();
        run_vertex("obj_done", 32'h0000_0000, 32'h0000_0000, 32'h4120_0000, 1'b1, 9'd160, 9'd120, 9'd10);
    endtask

    task automatic test_hold();
        int cyc;
        ready_in = 1'b0;
        accept(32'hC000_0000, 32'hBF80_0000, 32'h4100_0000, 1'b1);
        wait_valid(cyc);
        check_out("hold", cyc, 9'd96, 9'd152, 9'd8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            valid_in = (i == 2);
            @(posedge clk_in); #1;
            valid_in = 1'b0;
            n_checks++;
            if (valid_out !== 1'b1 || ready_out !== 1'b0 || coor_out !== {9'd96, 9'd152, 9'd8}) begin
                n_errs++;
                $display("FAIL hold_stable[%0d]: valid=%0b ready=%0b coor=(%0d,%0d,%0d) required 1/0/(96,152,8)",
                         i, valid_out, ready_out, coor_out[2], coor_out[1], coor_out[0]);
            end
        end
        ready_in = 1'b1;
        @(posedge clk_in); #1;
        n_checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            n_errs++;
            $display("FAIL hold_release: valid=%0b ready=%0b required 0/1", valid_out, ready_out);
        end
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            n_errs++;
            $display("FAIL hold_ignored_pulse: ready=%0b valid=%0b required 1/0", ready_out, valid_out);
        end
    endtask

    task automatic test_reset_mid_div();
        int seen;
        ready_in = 1'b1;
        accept(32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, 1'b1);
        repeat (10) @(posedge clk_in);
        #1;
        n_checks++;
        if (state_dbg !== 3'd2) begin
            n_errs++;
            $display("FAIL mid_state: state=%0d required 2", state_dbg);
        end
        rst_in = 1'b0;
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || obj_done_out !== 1'b0 || coor_out !== '0 || state_dbg !== 3'd0) begin
            n_errs++;
            $display("FAIL mid_reset: valid=%0b done=%0b coor=%h state=%0d required 0/0/0/0",
                     valid_out, obj_done_out, coor_out, state_dbg);
        end
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_in); #1;
            if (valid_out === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0 || ready_out !== 1'b1) begin
            n_errs++;
            $display("FAIL mid_abort: valid cycles=%0d ready=%0b required 0/1", seen, ready_out);
        end
    endtask

    task automatic test_accept_after_reset();
        int cyc;
        ready_in = 1'b1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in      = 1'b1;
        coor_in     = {32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, F_W1};
        obj_done_in = 1'b0;
        valid_in    = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        wait_valid(cyc);
        check_out("first_after_reset", cyc, 9'd224, 9'd56, 9'd4, 1'b0);
        @(posedge clk_in); #1;
    endtask

    initial begin
        test_reset();
        test_projection();
        test_saturation();
        test_obj_done();
        test_hold();
        test_reset_mid_div();
        test_accept_after_reset();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
